// File: rtl/m1553_timing_pkg.sv
// Shared types and default cycle counts for the MIL-STD-1553 bus-controller timing sequencer.
// Cycle defaults assume a 100 MHz clock.
package m1553_timing_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX        = 3'd1,
    WAIT_RESP = 3'd2,
    RX        = 3'd3,
    GAP       = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    RESP_NONE    = 3'd0,
    RESP_OK      = 3'd1,
    RESP_EARLY   = 3'd2,
    RESP_LATE    = 3'd3,
    RESP_NO_RESP = 3'd4
  } m1553_resp_e;

  localparam int unsigned DefRespMinCycles = 400;
  localparam int unsigned DefRespMaxCycles = 1200;
  localparam int unsigned DefTimeoutCycles = 1400;
  localparam int unsigned DefMinGapCycles  = 400;

  // Status-sync arrival time to response class, from the window flags of the response timer.
  function automatic m1553_resp_e classify_resp(input logic below_min, input logic in_window);
    if (below_min) begin
      return RESP_EARLY;
    end
    if (in_window) begin
      return RESP_OK;
    end
    return RESP_LATE;
  endfunction

endpackage

// File: rtl/m1553_timer.sv
// Saturating elapsed-cycle timer with terminal, penultimate and single-range flags.
// Count is 0 on the first cycle after a clear and holds at MaxValue, so it never wraps.
module m1553_timer #(
  parameter int unsigned MaxValue   = 1400,
  parameter int unsigned RangeMin_1 = 1,
  parameter int unsigned RangeMax_1 = 1,
  localparam int unsigned Width     = $clog2(MaxValue + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_done,
  output logic o_last,
  output logic o_below_1,
  output logic o_in_range_1
);

  localparam logic [Width-1:0] MaxV  = Width'(MaxValue);
  localparam logic [Width-1:0] LastV = Width'(MaxValue - 1);
  localparam logic [Width-1:0] MinV  = Width'(RangeMin_1);
  localparam logic [Width-1:0] RMaxV = Width'(RangeMax_1);

  logic [Width-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values and the simulation matches the synthesized flops.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      count <= '0;
    end else if (count != MaxV) begin
      count <= count + 1'b1;
    end
  end

  assign o_done       = (count == MaxV);
  assign o_last       = (count == LastV);
  assign o_below_1    = (count < MinV);
  assign o_in_range_1 = (count >= MinV) && (count <= RMaxV);

endmodule

// File: rtl/m1553_bc_timing_ctrl.sv
// MIL-STD-1553 BC timing sequencer: gates transmit starts to honour the intermessage gap
// and classifies RT status response time as early, in-window, late or absent.
module m1553_bc_timing_ctrl
  import m1553_timing_pkg::*;
#(
  parameter int unsigned RespMinCycles = DefRespMinCycles,
  parameter int unsigned RespMaxCycles = DefRespMaxCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  parameter int unsigned MinGapCycles  = DefMinGapCycles
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_req,
  input  logic       i_expect_resp,
  input  logic       i_tx_done,
  input  logic       i_rx_sync,
  input  logic       i_rx_done,
  output logic       o_tx_grant,
  output logic       o_busy,
  output logic       o_resp_valid,
  output logic [2:0] o_resp_status,
  output logic [2:0] o_state
);

  if (RespMinCycles >= RespMaxCycles) begin : g_chk_resp_order
    $fatal(1, "m1553_bc_timing_ctrl: RespMinCycles must be below RespMaxCycles");
  end
  if (RespMaxCycles >= TimeoutCycles) begin : g_chk_timeout_order
    $fatal(1, "m1553_bc_timing_ctrl: RespMaxCycles must be below TimeoutCycles");
  end
  if (MinGapCycles == 0) begin : g_chk_gap
    $fatal(1, "m1553_bc_timing_ctrl: MinGapCycles must be non-zero");
  end

  state_e      state;
  state_e      next_state;
  logic        state_change;
  logic        resp_pulse;
  m1553_resp_e resp_code;
  m1553_resp_e resp_status_q;

  logic resp_done;
  logic resp_last;
  logic resp_below_min;
  logic resp_in_window;
  logic gap_done;
  logic gap_last;
  logic gap_below;
  logic gap_in_range;
  logic timer_unused;

  // Both timers restart on every state entry, so the count is E for whichever state we are in.
  assign state_change = (next_state != state);

  m1553_timer #(
    .MaxValue  (TimeoutCycles),
    .RangeMin_1(RespMinCycles),
    .RangeMax_1(RespMaxCycles)
  ) u_resp_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (state_change),
    .o_done      (resp_done),
    .o_last      (resp_last),
    .o_below_1   (resp_below_min),
    .o_in_range_1(resp_in_window)
  );

  // GAP must last exactly MinGapCycles cycles (E = 0 .. MinGap-1), so it ends on the
  // penultimate count rather than the terminal one.
  m1553_timer #(
    .MaxValue  (MinGapCycles),
    .RangeMin_1(1),
    .RangeMax_1(MinGapCycles)
  ) u_gap_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (state_change),
    .o_done      (gap_done),
    .o_last      (gap_last),
    .o_below_1   (gap_below),
    .o_in_range_1(gap_in_range)
  );

  assign timer_unused = ^{resp_last, gap_done, gap_below, gap_in_range};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    resp_pulse = 1'b0;
    resp_code  = resp_status_q;
    unique case (state)
      IDLE: begin
        if (i_tx_req && o_tx_grant) begin
          next_state = TX;
        end
      end
      TX: begin
        if (i_tx_done) begin
          if (i_expect_resp) begin
            next_state = WAIT_RESP;
          end else begin
            next_state = GAP;
            resp_pulse = 1'b1;
            resp_code  = RESP_NONE;
          end
        end
      end
      WAIT_RESP: begin
        // A sync on the timeout cycle still counts as a (late) response.
        if (i_rx_sync) begin
          next_state = RX;
          resp_pulse = 1'b1;
          resp_code  = classify_resp(resp_below_min, resp_in_window);
        end else if (resp_done) begin
          next_state = GAP;
          resp_pulse = 1'b1;
          resp_code  = RESP_NO_RESP;
        end
      end
      RX: begin
        if (i_rx_done) begin
          next_state = GAP;
        end
      end
      GAP: begin
        if (gap_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so grant is already high on the first IDLE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_tx_grant    <= 1'b1;
      o_busy        <= 1'b0;
      o_resp_valid  <= 1'b0;
      resp_status_q <= RESP_NONE;
    end else begin
      state         <= next_state;
      o_tx_grant    <= (next_state == IDLE);
      o_busy        <= (next_state != IDLE);
      o_resp_valid  <= resp_pulse;
      resp_status_q <= resp_code;
    end
  end

  assign o_resp_status = resp_status_q;
  assign o_state       = state;

endmodule

// File: tb/tb_m1553_bc_timing_ctrl.sv
// Directed bench for m1553_bc_timing_ctrl: grant handshake, response windows, timeout,
// broadcast, intermessage gap length and mid-message reset.
module tb_m1553_bc_timing_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TX   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [2:0] R_NONE  = 3'd0;
  localparam logic [2:0] R_OK    = 3'd1;
  localparam logic [2:0] R_EARLY = 3'd2;
  localparam logic [2:0] R_LATE  = 3'd3;
  localparam logic [2:0] R_NORSP = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req;
  logic       expect_resp;
  logic       tx_done;
  logic       rx_sync;
  logic       rx_done;
  logic       tx_grant;
  logic       busy;
  logic       resp_valid;
  logic [2:0] resp_status;
  logic [2:0] state;

  int tests_run    = 0;
  int tests_failed = 0;

  m1553_bc_timing_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tx_req     (tx_req),
    .i_expect_resp(expect_resp),
    .i_tx_done    (tx_done),
    .i_rx_sync    (rx_sync),
    .i_rx_done    (rx_done),
    .o_tx_grant   (tx_grant),
    .o_busy       (busy),
    .o_resp_valid (resp_valid),
    .o_resp_status(resp_status),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_msg(input string tag);
    tests_run++;
    if (tx_grant !== 1'b1 || state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL %s pre_grant: grant=%b state=%0d, want grant=1 state=%0d", tag, tx_grant, state, S_IDLE);
    end
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    tests_run++;
    if (state !== S_TX || tx_grant !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s enter_tx: state=%0d grant=%b busy=%b, want state=%0d grant=0 busy=1",
               tag, state, tx_grant, busy, S_TX);
    end
  endtask

  task automatic finish_tx(input logic exp_resp);
    tx_done     = 1'b1;
    expect_resp = exp_resp;
    tick();
    tx_done     = 1'b0;
    expect_resp = 1'b0;
  endtask

  // Wait in WAIT_RESP until E = e, deliver the sync there and check the classification.
  task automatic sync_at(input string tag, input int e, input logic [2:0] want);
    int bad = 0;
    for (int i = 0; i < e; i++) begin
      if (state !== S_WAIT || resp_valid !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s wait_quiet: %0d bad cycles before sync, want 0", tag, bad);
    end
    rx_sync = 1'b1;
    tick();
    rx_sync = 1'b0;
    tests_run++;
    if (state !== S_RX || resp_valid !== 1'b1 || resp_status !== want) begin
      tests_failed++;
      $display("FAIL %s classify: state=%0d valid=%b status=%0d, want state=%0d valid=1 status=%0d",
               tag, state, resp_valid, resp_status, S_RX, want);
    end
  endtask

  // Count GAP cycles, requiring grant low throughout and high on the first IDLE cycle.
  task automatic check_gap(input string tag, input int already);
    int cnt = already;
    int bad = 0;
    while (state === S_GAP && cnt < 1000) begin
      if (tx_grant !== 1'b0 || resp_valid !== 1'b0) bad++;
      cnt++;
      tick();
    end
    tests_run++;
    if (cnt != 400 || bad != 0 || state !== S_IDLE || tx_grant !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s gap: cycles=%0d bad=%0d state=%0d grant=%b busy=%b, want cycles=400 bad=0 state=%0d grant=1 busy=0",
               tag, cnt, bad, state, tx_grant, busy, S_IDLE);
    end
  endtask

  task automatic finish_rx();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (state !== S_IDLE || tx_grant !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_status !== R_NONE) begin
      tests_failed++;
      $display("FAIL reset: state=%0d grant=%b busy=%b valid=%b status=%0d, want 0 1 0 0 0",
               state, tx_grant, busy, resp_valid, resp_status);
    end
  endtask

  task automatic test_resp_ok();
    start_msg("ok");
    finish_tx(1'b1);
    tests_run++;
    if (state !== S_WAIT || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ok enter_wait: state=%0d valid=%b, want state=%0d valid=0", state, resp_valid, S_WAIT);
    end
    sync_at("ok", 800, R_OK);
    // A second sync during RX must not produce another pulse.
    rx_sync = 1'b1;
    tick();
    rx_sync = 1'b0;
    tests_run++;
    if (state !== S_RX || resp_valid !== 1'b0 || resp_status !== R_OK) begin
      tests_failed++;
      $display("FAIL ok rx_sync_ignored: state=%0d valid=%b status=%0d, want state=%0d valid=0 status=%0d",
               state, resp_valid, resp_status, S_RX, R_OK);
    end
    finish_rx();
    check_gap("ok", 0);
  endtask

  task automatic test_boundary();
    int          e_tab[5]    = '{399, 400, 1200, 1201, 1400};
    logic [2:0]  want_tab[5] = '{R_EARLY, R_OK, R_OK, R_LATE, R_LATE};
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("bound_e%0d", e_tab[i]);
      start_msg(tag);
      finish_tx(1'b1);
      sync_at(tag, e_tab[i], want_tab[i]);
      finish_rx();
      check_gap(tag, 0);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int pulses = 0;
    start_msg("timeout");
    finish_tx(1'b1);
    while (resp_valid !== 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    tests_run++;
    if (n != 1401 || resp_status !== R_NORSP || state !== S_GAP) begin
      tests_failed++;
      $display("FAIL timeout: pulse_after=%0d status=%0d state=%0d, want pulse_after=1401 status=%0d state=%0d",
               n, resp_status, state, R_NORSP, S_GAP);
    end
    tick();
    if (resp_valid === 1'b1) pulses++;
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL timeout single_pulse: valid stayed high, want one-cycle pulse");
    end
    check_gap("timeout", 1);
  endtask

  task automatic test_broadcast();
    start_msg("bcast");
    finish_tx(1'b0);
    tests_run++;
    if (state !== S_GAP || resp_valid !== 1'b1 || resp_status !== R_NONE || tx_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL bcast status: state=%0d valid=%b status=%0d grant=%b, want state=%0d valid=1 status=%0d grant=0",
               state, resp_valid, resp_status, tx_grant, S_GAP, R_NONE);
    end
    tick();
    rx_sync = 1'b1;
    tick();
    rx_sync = 1'b0;
    tests_run++;
    if (state !== S_GAP || resp_valid !== 1'b0 || resp_status !== R_NONE) begin
      tests_failed++;
      $display("FAIL bcast stray_sync: state=%0d valid=%b status=%0d, want state=%0d valid=0 status=%0d",
               state, resp_valid, resp_status, S_GAP, R_NONE);
    end
    check_gap("bcast", 2);
  endtask

  task automatic test_ignored();
    tx_done = 1'b1;
    rx_sync = 1'b1;
    rx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    rx_sync = 1'b0;
    rx_done = 1'b0;
    tick();
    tests_run++;
    if (state !== S_IDLE || resp_valid !== 1'b0 || tx_grant !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_strays: state=%0d valid=%b grant=%b busy=%b, want state=%0d valid=0 grant=1 busy=0",
               state, resp_valid, tx_grant, busy, S_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    start_msg("rst_pre");
    finish_tx(1'b1);
    sync_at("rst_pre", 10, R_EARLY);
    finish_rx();
    check_gap("rst_pre", 0);
    start_msg("rst_mid");
    finish_tx(1'b1);
    repeat (600) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (state !== S_IDLE || tx_grant !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_status !== R_NONE) begin
      tests_failed++;
      $display("FAIL rst_mid: state=%0d grant=%b busy=%b valid=%b status=%0d, want 0 1 0 0 0",
               state, tx_grant, busy, resp_valid, resp_status);
    end
    for (int i = 0; i < 5; i++) begin
      if (resp_valid === 1'b1) pulses++;
      tick();
    end
    tests_run++;
    if (pulses != 0 || state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL rst_mid after: pulses=%0d state=%0d, want pulses=0 state=%0d", pulses, state, S_IDLE);
    end
  endtask

  initial begin
    rst         = 1'b1;
    tx_req      = 1'b0;
    expect_resp = 1'b0;
    tx_done     = 1'b0;
    rx_sync     = 1'b0;
    rx_done     = 1'b0;
    tick();
    test_reset();
    test_resp_ok();
    test_boundary();
    test_timeout();
    test_broadcast();
    test_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded 2 ms, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
